spi_master_ctrl: RTL
====================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per transfer, at least 2.
REQ-002 SHALL have parameter NUM_CS, default 2: number of chip selects, at least 1.
REQ-003 SHALL have parameter DIV_W, default 4: width of the clock-divider input.
REQ-004 SHALL define local CS_W = max(1, clog2(NUM_CS)).
REQ-005 clk  in  1  single clock; every flop on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 ena  in  1  enable; when low, start is ignored.
REQ-008 start  in  1  transfer request, sampled in IDLE only.
REQ-009 cs_sel  in  CS_W  index of the target chip select.
REQ-010 cpol  in  1  SPI clock polarity for the requested transfer.
REQ-011 cpha  in  1  SPI clock phase for the requested transfer.
REQ-012 clk_div  in  DIV_W  half-period of SCK minus 1, in clk cycles.
REQ-013 tx_data  in  DATA_W  word to send, MSB first.
REQ-014 rx_data  out  DATA_W  last received word.
REQ-015 busy  out  1  high while a transfer is in progress.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 spi_cs_n  out  NUM_CS  active-low chip selects.
REQ-018 spi_sck  out  1  SPI clock.
REQ-019 spi_mosi  out  1  serial data out.
REQ-020 spi_miso  in  1  serial data in.

Function
REQ-021 SHALL implement states IDLE, SETUP, SHIFT and HOLD; busy SHALL equal (state != IDLE).
REQ-022 Start acceptance:
- start is accepted on an edge where state=IDLE, ena=1, start=1 and cs_sel<NUM_CS.
- On that edge the block latches tx_data, cs_sel, cpol, cpha and clk_div, and enters SETUP.
REQ-023 A start with cs_sel>=NUM_CS SHALL be ignored: no state change, no busy, no done.
REQ-024 start while busy SHALL be ignored, with no effect on the current transfer.
REQ-025 Let H = latched clk_div + 1. SETUP SHALL last H cycles, SHIFT 2*DATA_W*H cycles, and HOLD H cycles.
REQ-026 From SETUP entry until HOLD exit, spi_cs_n[latched cs_sel] SHALL be 0; all other bits SHALL be 1 at all times.
REQ-027 spi_sck SHALL equal the latched cpol outside SHIFT, and SHALL toggle every H cycles within SHIFT, giving exactly 2*DATA_W edges.
REQ-028 cpha=0 bit timing:
- mosi presents the MSB on SETUP entry.
- spi_miso is sampled on each odd (leading) edge.
- mosi shifts to the next bit on each even (trailing) edge except the last.
REQ-029 cpha=1 bit timing:
- mosi is driven with the next bit on each odd edge.
- spi_miso is sampled on each even edge.
REQ-030 The receive shift register SHALL shift left with spi_miso entering at bit 0; rx_data SHALL update only on the cycle done asserts.
REQ-031 On HOLD exit the block SHALL return to IDLE, assert done for exactly one cycle, and deassert all of spi_cs_n in that same cycle.
REQ-032 Latency: done SHALL assert exactly (2*DATA_W+2)*H cycles after the accepting edge.
REQ-033 A new start may be accepted in the cycle done is high, giving back-to-back transfers with one IDLE cycle between them.
REQ-034 spi_mosi SHALL be 0 in IDLE.
REQ-035 ena going low mid-transfer SHALL NOT abort the transfer.
REQ-036 clk_div=0 (H=1) SHALL work, with SCK at clk/2.

Reset
REQ-037 Asserting rst_n low SHALL immediately set:
- state to IDLE;
- spi_cs_n to all 1s;
- latched cpol to 0, so spi_sck is 0;
- spi_mosi, busy and done to 0;
- rx_data and the shift registers to 0.
REQ-038 Reset mid-transfer SHALL discard the transfer with no done pulse; the block SHALL accept a new start on the first edge after rst_n rises.

Verification
REQ-039 Mode 0 echo: DATA_W=8, clk_div=0, cs_sel=1, tx_data=0xA5, spi_miso looped to spi_mosi -> spi_cs_n=2'b01 for 18 cycles, done at cycle 18, rx_data=0xA5.
REQ-040 Mode 3, clk_div=3: tx_data=0x3C, slave model returns 0xC3 -> SCK idles high, 8 rising sample edges spaced 8 cycles apart, done at cycle 72, rx_data=0xC3.
REQ-041 Ignored requests:
- cs_sel=2 with NUM_CS=2 -> busy stays 0 and no done.
- start with ena=0 -> busy stays 0.
- start pulsed while busy -> exactly one done.
REQ-042 Reset mid-transfer: rst_n low at cycle 7 of a 0xFF transfer -> spi_cs_n=2'b11, spi_sck=0, busy=0 and no done; a subsequent transfer of 0x12 completes normally.
REQ-043 Back-to-back: start held high across done -> second transfer's SETUP begins one cycle after done, and rx_data updates for each transfer.
REQ-044 Parameter sweep: DATA_W=16, NUM_CS=4, cs_sel=3, tx_data=0xBEEF looped back -> only spi_cs_n[3] goes low, and rx_data=0xBEEF after 34*H cycles.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI master controller: one configurable transfer at a time, MSB first,
// selectable CPOL/CPHA, SCK half-period of (clk_div+1) clk cycles and a
// one-hot active-low chip select picked per transfer.
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 4,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int                EC_W      = $clog2(2 * DATA_W + 1);
  localparam logic [EC_W-1:0]   LAST_EDGE = EC_W'(2 * DATA_W);
  // NUM_CS widened by one bit so the range test never compares against an
  // unrepresentable constant.
  localparam logic [CS_W:0]     NUM_CS_L  = (CS_W + 1)'(NUM_CS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_q,    state_d;
  logic [DIV_W-1:0]    div_cnt_q,  div_cnt_d;
  logic [EC_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic [DIV_W-1:0]    clk_div_q,  clk_div_d;
  logic                cpol_q,     cpol_d;
  logic                cpha_q,     cpha_d;
  logic [DATA_W-1:0]   tx_sr_q,    tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q,    rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q,  rx_data_d;
  logic [NUM_CS-1:0]   cs_n_q,     cs_n_d;
  logic                sck_q,      sck_d;
  logic                mosi_q,     mosi_d;
  logic                done_q,     done_d;

  logic                half_done;
  logic                cs_ok;
  logic                edge_evt;
  logic [EC_W-1:0]     edge_nxt;
  logic                edge_smp;
  logic                edge_drv;

  // SCK edge bookkeeping: which edge comes next and whether it samples or drives
  always_comb begin
    half_done = (div_cnt_q == clk_div_q);
    cs_ok     = ({1'b0, cs_sel} < NUM_CS_L);
    edge_nxt  = edge_cnt_q + EC_W'(1);
    edge_evt  = half_done &&
                ((state_q == SETUP) ||
                 ((state_q == SHIFT) && (edge_cnt_q != LAST_EDGE)));
    // cpha=0 samples on odd edges, cpha=1 on even edges
    edge_smp  = edge_nxt[0] ^ cpha_q;
    // the final edge of a cpha=0 transfer must not advance mosi
    edge_drv  = !edge_smp && (edge_nxt != LAST_EDGE);
  end

  // Next-state and next-output computation for the whole controller
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = half_done ? '0 : div_cnt_q + DIV_W'(1);
    edge_cnt_d = edge_cnt_q;
    clk_div_d  = clk_div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (ena && start && cs_ok) begin
          state_d    = SETUP;
          edge_cnt_d = '0;
          clk_div_d  = clk_div;
          cpol_d     = cpol;
          cpha_d     = cpha;
          cs_n_d     = ~(NUM_CS'(1) << cs_sel);
          sck_d      = cpol;
          // MSB goes out immediately; cpha=1 re-drives it on the first edge
          mosi_d     = tx_data[DATA_W-1];
          tx_sr_d    = cpha ? tx_data : (tx_data << 1);
          rx_sr_d    = '0;
        end
      end
      SETUP: begin
        if (half_done) state_d = SHIFT;
      end
      SHIFT: begin
        if (half_done && (edge_cnt_q == LAST_EDGE)) state_d = HOLD;
      end
      HOLD: begin
        if (half_done) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          cs_n_d    = '1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sr_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (edge_evt) begin
      sck_d      = ~sck_q;
      edge_cnt_d = edge_nxt;
      if (edge_smp) rx_sr_d = {rx_sr_q[DATA_W-2:0], spi_miso};
      if (edge_drv) begin
        mosi_d  = tx_sr_q[DATA_W-1];
        tx_sr_d = tx_sr_q << 1;
      end
    end
  end

  // State and registered outputs; reset parks the bus idle with SCK low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      clk_div_q  <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      cs_n_q     <= '1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      clk_div_q  <= clk_div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;

endmodule
